// File: rtl/unsigned_mul_8x8_ha_pkg.sv
// Shared definitions for the 8x8 unsigned multiplier half-adder array reducer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: row geometry (row count, carry/sum vector widths), product width,
// row-counter type, FSM state enum, registered-row struct and a helper that
// turns a row index into its bit weight shift.
package unsigned_mul_8x8_ha_pkg;

  // Row geometry of the half-adder array handed to the reducer.
  localparam int unsigned ROWS      = 4;
  localparam int unsigned B_W       = 7;   // bottom (carry) vector width
  localparam int unsigned T_W       = 9;   // top (sum) vector width
  localparam int unsigned PROD_W    = 16;  // product width presented to the consumer
  localparam int unsigned ROW_VAL_W = PROD_W + 1; // widest weighted row / full sum

  localparam int unsigned CNT_W     = $clog2(ROWS);
  localparam int unsigned SHIFT_W   = CNT_W + 1;

  typedef logic [CNT_W-1:0] row_idx_t;

  localparam row_idx_t LAST_ROW = row_idx_t'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One captured array row: sum vector in the upper field, carry vector below.
  typedef struct packed {
    logic [T_W-1:0] t;
    logic [B_W-1:0] b;
  } ha_row_t;

  // Row k carries weight 2^(2k): each array row is two partial products deep.
  function automatic logic [SHIFT_W-1:0] row_shift(input row_idx_t idx);
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/ha_row_weight.sv
// Weights one half-adder array row: value = (t + (b << 2)) << 2*row.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_t   [T_W-1:0]   top (sum) vector of the row
//   i_b   [B_W-1:0]   bottom (carry) vector of the row
//   i_row [CNT_W-1:0] row index, selects the 2^(2*row) weight
//   o_val [OUT_W-1:0] weighted row value (17 bits by default)
module ha_row_weight
  import unsigned_mul_8x8_ha_pkg::*;
#(
  parameter int unsigned OUT_W = ROW_VAL_W
)
(
  input  logic [T_W-1:0]   i_t,
  input  logic [B_W-1:0]   i_b,
  input  logic [CNT_W-1:0] i_row,
  output logic [OUT_W-1:0] o_val
);

  logic [OUT_W-1:0] w_base;

  // Carry bit b[i] sits two places above sum bit t[i] within the same row.
  assign w_base = OUT_W'(i_t) + (OUT_W'(i_b) << 2);

  // A narrower OUT_W simply drops the bits above it, which is the same as
  // reducing the final sum modulo 2^OUT_W.
  assign o_val = w_base << row_shift(i_row);

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// Reduces the 4-row half-adder array of an 8x8 unsigned multiply to a 16-bit product.
// Latency: 5 cycles accept-to-out_valid (one capture edge, four row-add edges).
// Backpressure: in_ready low while busy; product/out_valid held until out_ready.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid / in_ready        row handshake; all 64 row bits captured on accept
//   ha_array_k_b [6:0]         carry vector of row k (k = 0..3)
//   ha_array_k_t [8:0]         sum vector of row k (k = 0..3)
//   out_valid / out_ready      product handshake
//   product [15:0]             sum of weighted rows modulo 2^16, zero outside DONE
//   ovf                        bit 16 of the sum while in DONE, zero otherwise;
//                              only present when HA_REDUCER_OVF_EN is defined
//
// Build option: define HA_REDUCER_OVF_EN to widen the accumulator to 17 bits and
// expose ovf. Without it the accumulator is 16 bits and wraps identically.
module unsigned_mul_8x8_ha_array_reducer
  import unsigned_mul_8x8_ha_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [B_W-1:0]        ha_array_0_b,
  input  logic [B_W-1:0]        ha_array_1_b,
  input  logic [B_W-1:0]        ha_array_2_b,
  input  logic [B_W-1:0]        ha_array_3_b,
  input  logic [T_W-1:0]        ha_array_0_t,
  input  logic [T_W-1:0]        ha_array_1_t,
  input  logic [T_W-1:0]        ha_array_2_t,
  input  logic [T_W-1:0]        ha_array_3_t,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PROD_W-1:0]     product
`ifdef HA_REDUCER_OVF_EN
  ,
  output logic                  ovf
`endif
);

`ifdef HA_REDUCER_OVF_EN
  localparam int unsigned ACC_W = PROD_W + 1;
`else
  localparam int unsigned ACC_W = PROD_W;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  ha_row_t          r_rows [ROWS];
  row_idx_t         r_cnt;
  logic [ACC_W-1:0] r_acc;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_add;
  ha_row_t          w_row_sel;
  logic [ACC_W-1:0] w_row_val;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    w_add       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // One row per cycle; the edge that adds the last row enters DONE.
        w_add = 1'b1;
        if (r_cnt == LAST_ROW) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Row select and weighting: a single weighter shared across the four rows
  // ---------------------------------------------------------------------------
  always_comb begin
    w_row_sel = r_rows[r_cnt];
  end

  ha_row_weight #(
    .OUT_W (ACC_W)
  ) u_ha_row_weight (
    .i_t   (w_row_sel.t),
    .i_b   (w_row_sel.b),
    .i_row (r_cnt),
    .o_val (w_row_val)
  );

  // ---------------------------------------------------------------------------
  // Datapath: row capture, row counter, accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ROWS; k++) begin
        r_rows[k] <= '0;
      end
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      // Rows are only sampled here, so input activity at any other time
      // cannot disturb a result in progress.
      r_rows[0] <= {ha_array_0_t, ha_array_0_b};
      r_rows[1] <= {ha_array_1_t, ha_array_1_b};
      r_rows[2] <= {ha_array_2_t, ha_array_2_b};
      r_rows[3] <= {ha_array_3_t, ha_array_3_b};
      r_cnt     <= '0;
      r_acc     <= '0;
    end else if (w_add) begin
      r_acc <= r_acc + w_row_val;
      r_cnt <= r_cnt + row_idx_t'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: result is only visible while presented in DONE
  // ---------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign product   = (r_state == ST_DONE) ? r_acc[PROD_W-1:0] : '0;

`ifdef HA_REDUCER_OVF_EN
  assign ovf = (r_state == ST_DONE) ? r_acc[ACC_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reducer.sv
// Self-checking bench for the half-adder array reducer: scoreboard queue of
// expected sums pushed at accept and popped when out_valid is observed.
// Outputs sampled 1 time unit after each rising edge.
module tb_unsigned_mul_8x8_ha_array_reducer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
`ifdef HA_REDUCER_OVF_EN
  logic        ovf;
`endif
  logic [8:0]  tv [4];
  logic [6:0]  bv [4];

  int          n_vec;
  int          n_err;
  logic [16:0] sb_q [$];

  unsigned_mul_8x8_ha_array_reducer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (bv[0]),
    .ha_array_1_b (bv[1]),
    .ha_array_2_b (bv[2]),
    .ha_array_3_b (bv[3]),
    .ha_array_0_t (tv[0]),
    .ha_array_1_t (tv[1]),
    .ha_array_2_t (tv[2]),
    .ha_array_3_t (tv[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
`ifdef HA_REDUCER_OVF_EN
    ,
    .ovf          (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of each row weighted (t + 4*b) * 4^k, full 17-bit result.
  function automatic logic [16:0] model();
    int sum;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      sum += (int'(tv[k]) + 4 * int'(bv[k])) * (1 << (2 * k));
    end
    return sum[16:0];
  endfunction

  task automatic clear_rows();
    for (int k = 0; k < 4; k++) begin
      tv[k] = '0;
      bv[k] = '0;
    end
  endtask

  task automatic scramble_rows();
    for (int k = 0; k < 4; k++) begin
      tv[k] = 9'($urandom);
      bv[k] = 7'($urandom);
    end
  endtask

  // Called at posedge+1 in IDLE with rows already set.
  task automatic run(input string tag, input int stall);
    int          k;
    logic [16:0] exp;
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    sb_q.push_back(model());
    tick();                                  // accept edge
    in_valid = 1'b0;
    scramble_rows();                         // must not affect the result
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
      if (k == 2) chk({tag, "_prod_busy"}, 32'(product), 32'd0);
    end
    chk({tag, "_latency"}, 32'(k), 32'd4);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    exp = (sb_q.size() > 0) ? sb_q[0] : 17'd0;
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_stall_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_prod"}, 32'(product), 32'(exp[15:0]));
      chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      in_valid = 1'b1;                       // ignored while busy
      scramble_rows();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    chk({tag, "_product"}, 32'(product), 32'(exp[15:0]));
`ifdef HA_REDUCER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp[16]));
`endif
    tick();
    chk({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int saw_vld;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_rows();

    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    tick();
    rst_n = 1'b1;                            // first edge after this accepts

    clear_rows(); tv[0] = 9'h1FF; bv[0] = 7'h7F;
    chk("model_row0", 32'(model()), 32'd1019);
    run("row0_ones", 0);

    clear_rows(); tv[3] = 9'h100;
    run("row3_t8", 0);

    clear_rows(); bv[2] = 7'h01;
    run("row2_b0", 0);

    for (int k = 0; k < 4; k++) begin tv[k] = 9'h1FF; bv[k] = 7'h7F; end
    run("all_ones", 0);

    scramble_rows();
    run("stall", 10);

    for (int i = 0; i < 6; i++) begin
      scramble_rows();
      run("rand", i % 3);
    end

    // Reset two cycles into accumulation: result must be dropped.
    scramble_rows();
    in_valid = 1'b1;
    sb_q.push_back(model());
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    tick();
    rst_n   = 1'b1;
    saw_vld = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) saw_vld++;
    end
    chk("midrst_no_vld", 32'(saw_vld), 32'd0);
    chk("midrst_sb_empty", 32'(sb_q.size()), 32'd0);

    clear_rows(); tv[1] = 9'h0AB; bv[3] = 7'h15;
    run("after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unsigned_mul_8x8_ha_array_reducer.md
UNSIGNED_MUL_8X8_HA_ARRAY_REDUCER -- requirements
Module: unsigned_mul_8x8_ha_array_reducer

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  input  1  ha_array rows valid.
REQ-004 SHALL have ports: in_ready  output  1  reducer can accept rows.
REQ-005 SHALL have ports: ha_array_k_b  input  7  bottom (carry) vector of row k, k = 0..3.
REQ-006 SHALL have ports: ha_array_k_t  input  9  top (sum) vector of row k, k = 0..3.
REQ-007 SHALL have ports: out_valid  output  1  product valid.
REQ-008 SHALL have ports: out_ready  input  1  consumer accepts product.
REQ-009 SHALL have ports: product  output  16  reduced product, modulo 2^16.
REQ-010 SHALL have port ovf  output  1  product exceeded 16 bits, present only per REQ-024.

Function
REQ-011 Bit weights SHALL be: t[i] = 2^(i+2k); b[i] = 2^(i+2+2k); row k value = (t + (b << 2)) << 2k.
REQ-012 Accept SHALL occur on a rising edge with in_valid && in_ready; all 64 row bits are registered on that edge.
REQ-013 FSM states: IDLE, ACCUM, DONE; reset state IDLE.
REQ-014 IDLE: in_ready = 1, out_valid = 0; on accept -> ACCUM, row counter = 0, 17-bit accumulator = 0.
REQ-015 ACCUM: in_ready = 0; each cycle adds row[counter] to the accumulator and increments the counter; after adding row 3 -> DONE.
REQ-016 Latency SHALL be exactly 5 cycles: accept at edge N, rows added at edges N+1..N+4, out_valid = 1 in the cycle after edge N+4.
REQ-017 DONE: out_valid = 1; product = accumulator[15:0], held stable until out_ready; on out_valid && out_ready -> IDLE.
REQ-018 in_ready SHALL be 0 in ACCUM and DONE; there is no back-to-back overlap; maximum throughput is one product per 6 cycles with out_ready held at 1.
REQ-019 Input changes outside the accept edge SHALL have no effect on the result.
REQ-020 product SHALL be 0 whenever the FSM is not in DONE.

Reset
REQ-021 Asserting rst_n low at any time, including mid-ACCUM or in DONE, SHALL immediately force IDLE, in_ready = 1, out_valid = 0, product = 0, ovf = 0, accumulator = 0, counter = 0, registered rows = 0.
REQ-022 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.
REQ-023 A result in flight at reset SHALL be discarded and never presented.

Configuration
REQ-024 Macro HA_REDUCER_OVF_EN defined: port ovf exists and equals accumulator[16] while in DONE, 0 otherwise. Undefined: no ovf port, accumulator is 16 bits, and product wraps modulo 2^16 identically.

Structure
REQ-025 Shared package unsigned_mul_8x8_ha_pkg SHALL hold: row count (4), B width (7), T width (9), product width (16), FSM state enum.
REQ-026 Sub-module ha_row_weight (combinational: t, b, row index -> 17-bit weighted row value) SHALL be instantiated once and muxed by the row counter.

Verification
REQ-027 Reset: rst_n = 0 -> in_ready = 1, out_valid = 0, product = 0.
REQ-028 Row 0: t = 0x1FF and b = 0x7F, all other rows 0 -> product = 1019 exactly 5 cycles after accept.
REQ-029 Row 3: only t[8] = 1 -> product = 16384; row 2: only b[0] = 1 -> product = 64.
REQ-030 All rows all ones -> product = 21079; ovf = 1 (macro on) or no ovf port (macro off).
REQ-031 Backpressure: out_ready = 0 for 10 cycles -> out_valid and product stay stable, in_ready = 0; release -> IDLE the next cycle; new in_valid during the stall is ignored.
REQ-032 Reset mid-ACCUM (2 cycles after accept) -> IDLE immediately; no out_valid follows; the next accept yields the correct new result.
